// File: rtl/arduino_bridge_pkg.sv
// arduino_bridge_pkg
//   Shared types and constants for the Arduino command bridge.
//   op_e     : command byte opcode field [7:6]
//   state_e  : bridge FSM states
//   incAddr  : conditional wrap-around increment of the programmable address
package arduino_bridge_pkg;

    localparam int ADDR_W       = 20;
    localparam int DATA_W       = 16;
    localparam int PROG_ADDR_W  = 12;
    localparam int NIB_PER_WORD = 4;

    typedef enum logic [1:0] {
        OP_ADDR_LO = 2'b00,
        OP_ADDR_HI = 2'b01,
        OP_READ    = 2'b10,
        OP_WRITE   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        RD_WAIT,
        RD_CAP,
        WR,
        ACK
    } state_e;

    // The 12-bit field wraps naturally: 0xFFF + 1 -> 0x000.
    function automatic logic [PROG_ADDR_W-1:0] incAddr(
        input logic [PROG_ADDR_W-1:0] a,
        input logic                   en
    );
        return a + PROG_ADDR_W'(en);
    endfunction

endpackage

// File: rtl/arduino_bridge_sync_2ff.sv
// sync_2ff
//   Two-flop synchronizer for signals crossing into the clk domain.
//   Ports:
//     clk  : destination clock
//     rstN : asynchronous active-low reset, clears both stages
//     d    : asynchronous input
//     q    : synchronized output (two clk edges of latency)
module sync_2ff
    import arduino_bridge_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/arduino_bridge.sv
// arduino_bridge
//   Command bridge between the Arduino 8-bit parallel bus and port B of the
//   dual-port data RAM. One command byte is executed per four-phase req/ack
//   handshake; the byte is [7:6] opcode, [5:0] payload.
//   Ports:
//     clk, rst          : clock, asynchronous active-low reset
//     req, data_in      : Arduino strobe (asynchronous) and command byte
//     ack, data_out     : handshake acknowledge and read-result byte
//     busy              : high whenever the FSM is not IDLE
//     ard_addr          : RAM port-B address (only [11:0] programmable)
//     ard_wen, ard_wdata: RAM port-B single-cycle write strobe and data
//     ard_rdata         : RAM port-B read data, one cycle after the address
module arduino_bridge #(
    parameter int ADDR_W = arduino_bridge_pkg::ADDR_W,
    parameter int DATA_W = arduino_bridge_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [7:0]        data_in,
    output logic              ack,
    output logic [7:0]        data_out,
    output logic              busy,
    output logic [ADDR_W-1:0] ard_addr,
    output logic              ard_wen,
    output logic [DATA_W-1:0] ard_wdata,
    input  logic [DATA_W-1:0] ard_rdata
);

    import arduino_bridge_pkg::*;

    localparam logic [1:0] LAST_NIB = 2'(NIB_PER_WORD - 1);

    state_e                 state;
    logic [7:0]             cmd;
    logic [PROG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]      wbuf;
    logic [1:0]             nibCnt;
    logic                   reqSync;
    logic                   reqPrev;
    op_e                    cmdOp;
    logic [DATA_W-1:0]      nextWbuf;

    sync_2ff #(.WIDTH(1)) uReqSync (
        .clk  (clk),
        .rstN (rst),
        .d    (req),
        .q    (reqSync)
    );

    assign cmdOp    = op_e'(cmd[7:6]);
    // Nibbles arrive MSB-first, so each one shifts in at the bottom.
    assign nextWbuf = {wbuf[DATA_W-5:0], cmd[3:0]};
    assign ard_addr = {{(ADDR_W-PROG_ADDR_W){1'b0}}, addr};
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cmd       <= '0;
            addr      <= '0;
            wbuf      <= '0;
            nibCnt    <= '0;
            reqPrev   <= 1'b0;
            ack       <= 1'b0;
            data_out  <= '0;
            ard_wen   <= 1'b0;
            ard_wdata <= '0;
        end else begin
            reqPrev <= reqSync;
            // ack trails the ACK state by one cycle; this gives the 1-cycle
            // pulse when req has already dropped by the time ACK is reached.
            ack     <= (state == ACK);
            ard_wen <= 1'b0;

            unique case (state)
                IDLE: begin
                    // Only a fresh rising edge starts a command, so a req
                    // held high after a command does not retrigger.
                    if (reqSync && !reqPrev) begin
                        cmd   <= data_in;
                        state <= EXEC;
                    end
                end

                EXEC: begin
                    case (cmdOp)
                        OP_ADDR_LO: begin
                            addr[5:0] <= cmd[5:0];
                            nibCnt    <= '0;
                            state     <= ACK;
                        end
                        OP_ADDR_HI: begin
                            addr[11:6] <= cmd[5:0];
                            nibCnt     <= '0;
                            state      <= ACK;
                        end
                        OP_READ: begin
                            // Address is already on the RAM; give it a cycle.
                            state <= RD_WAIT;
                        end
                        OP_WRITE: begin
                            wbuf <= nextWbuf;
                            if (nibCnt == LAST_NIB) begin
                                nibCnt    <= '0;
                                ard_wdata <= nextWbuf;
                                ard_wen   <= 1'b1;
                                state     <= WR;
                            end else begin
                                nibCnt <= nibCnt + 2'd1;
                                state  <= ACK;
                            end
                        end
                    endcase
                end

                RD_WAIT: state <= RD_CAP;

                RD_CAP: begin
                    data_out <= cmd[0] ? ard_rdata[15:8] : ard_rdata[7:0];
                    addr     <= incAddr(addr, cmd[1]);
                    state    <= ACK;
                end

                // ard_wen is high during this cycle with the old address;
                // the increment lands on the same edge that clears ard_wen.
                WR: begin
                    addr  <= incAddr(addr, cmd[4]);
                    state <= ACK;
                end

                ACK: begin
                    if (!reqSync) state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arduino_bridge.sv
module tb_arduino_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic        ack;
    logic [7:0]  data_out;
    logic        busy;
    logic [19:0] ard_addr;
    logic        ard_wen;
    logic [15:0] ard_wdata;
    logic [15:0] ard_rdata;

    always #5 clk = ~clk;

    arduino_bridge #(.ADDR_W(20), .DATA_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data_in   (data_in),
        .ack       (ack),
        .data_out  (data_out),
        .busy      (busy),
        .ard_addr  (ard_addr),
        .ard_wen   (ard_wen),
        .ard_wdata (ard_wdata),
        .ard_rdata (ard_rdata)
    );

    // RAM port B: registered read, loaded once from the reference image.
    logic [15:0] ram    [4096];
    logic [15:0] refMem [4096];
    bit          ramLoaded = 1'b0;

    always @(posedge clk) begin
        if (!ramLoaded) begin
            for (int i = 0; i < 4096; i++) ram[i] <= refMem[i];
            ramLoaded <= 1'b1;
        end else if (ard_wen) begin
            ram[ard_addr[11:0]] <= ard_wdata;
        end
        ard_rdata <= ram[ard_addr[11:0]];
    end

    // Behavioural model: architectural state after each completed command.
    logic [11:0] mAddr = '0;
    int          mNib = 0;
    logic [15:0] mWbuf = '0;
    logic [7:0]  mData = '0;
    bit          mSettled = 1'b1;
    logic [27:0] wq[$];

    int          nChecks = 0;
    int          nPass = 0;
    int          wenCount = 0;
    logic [19:0] lastWAddr = '0;
    logic [15:0] lastWData = '0;
    int          lastLat = 0;
    logic [27:0] wExp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int expLat(input logic [7:0] c);
        case (c[7:6])
            2'b10:   return 4;
            2'b11:   return (mNib == 3) ? 3 : 2;
            default: return 2;
        endcase
    endfunction

    task automatic modelCmd(input logic [7:0] c);
        case (c[7:6])
            2'b00: begin mAddr[5:0] = c[5:0]; mNib = 0; end
            2'b01: begin mAddr[11:6] = c[5:0]; mNib = 0; end
            2'b10: begin
                mData = c[0] ? refMem[mAddr][15:8] : refMem[mAddr][7:0];
                if (c[1]) mAddr = mAddr + 12'd1;
            end
            default: begin
                mWbuf = {mWbuf[11:0], c[3:0]};
                if (mNib == 3) begin
                    wq.push_back({mAddr, mWbuf});
                    refMem[mAddr] = mWbuf;
                    mNib = 0;
                    if (c[4]) mAddr = mAddr + 12'd1;
                end else begin
                    mNib++;
                end
            end
        endcase
    endtask

    task automatic modelReset();
        mAddr = '0; mNib = 0; mWbuf = '0; mData = '0;
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst) begin
            chk("addrUpperZero", {12'h0, ard_addr[19:12]}, 32'h0);
            if (ard_wen) begin
                wenCount++;
                lastWAddr = ard_addr;
                lastWData = ard_wdata;
                if (wq.size() == 0) begin
                    chk("unexpectedWen", 32'd1, 32'd0);
                end else begin
                    wExp = wq.pop_front();
                    chk("wrAddr", {12'h0, ard_addr}, {20'h0, wExp[27:16]});
                    chk("wrData", {16'h0, ard_wdata}, {16'h0, wExp[15:0]});
                end
            end
            if (mSettled && !busy && !ack) begin
                chk("idleAddr", {12'h0, ard_addr}, {20'h0, mAddr});
                chk("dataOut", {24'h0, data_out}, {24'h0, mData});
            end
        end
    end

    task automatic doCmd(input logic [7:0] c, input int hold);
        int n;
        int lat;
        lat = expLat(c);
        mSettled = 1'b0;
        modelCmd(c);
        data_in = c;
        @(posedge clk); #1;
        req = 1'b1;
        n = 0;
        while (!ack && n < 40) begin @(posedge clk); #1; n++; end
        chk("ackLatency", n, lat + 3);
        lastLat = n;
        repeat (hold) begin @(posedge clk); #1; chk("ackHeld", {31'h0, ack}, 32'd1); end
        req = 1'b0;
        n = 0;
        while (ack && n < 40) begin @(posedge clk); #1; n++; end
        chk("ackFall", n, 4);
        chk("busyAfterAck", {31'h0, busy}, 32'd0);
        mSettled = 1'b1;
    endtask

    // req dropped one cycle after the command is latched.
    task automatic doEarlyDrop(input logic [7:0] c);
        int hi;
        mSettled = 1'b0;
        modelCmd(c);
        data_in = c;
        @(posedge clk); #1;
        req = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        req = 1'b0;
        hi = 0;
        repeat (20) begin @(posedge clk); #1; if (ack) hi++; end
        chk("earlyDropAckWidth", hi, 1);
        chk("earlyDropBusy", {31'h0, busy}, 32'd0);
        mSettled = 1'b1;
    endtask

    task automatic chkZeroOutputs(input string name);
        chk(name, {23'h0, ack, busy, ard_wen, data_out}, 32'h0);
        chk(name, {12'h0, ard_addr}, 32'h0);
        chk(name, {16'h0, ard_wdata}, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", nPass, nChecks);
        $fatal(1);
    end

    initial begin
        int w0;
        for (int i = 0; i < 4096; i++) refMem[i] = 16'($urandom);
        refMem[12'h045] = 16'hBEEF;

        // Reset with random bus activity: outputs stay quiet.
        repeat (8) begin
            @(negedge clk);
            req = 1'($urandom);
            data_in = 8'($urandom);
            #1 chkZeroOutputs("resetOutputs");
        end
        req = 1'b0; data_in = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("postResetBusy", {31'h0, busy}, 32'd0);
        chk("postResetAck", {31'h0, ack}, 32'd0);

        // Address assembly plus byte reads.
        doCmd(8'h05, 0);
        doCmd(8'h41, 0);
        chk("addr045", {12'h0, ard_addr}, 32'h00045);
        doCmd(8'h80, 0);
        chk("readLo", {24'h0, data_out}, 32'hEF);
        chk("readLatency", lastLat, 7);
        doCmd(8'h81, 0);
        chk("readHi", {24'h0, data_out}, 32'hBE);
        chk("readNoInc", {12'h0, ard_addr}, 32'h00045);

        // Four-nibble write with increment on the last nibble.
        doCmd(8'h10, 0);
        doCmd(8'h40, 0);
        w0 = wenCount;
        doCmd(8'hCC, 0);
        doCmd(8'hCA, 0);
        doCmd(8'hCF, 0);
        doCmd(8'hDE, 0);
        chk("wr4Latency", lastLat, 6);
        chk("cafeCount", wenCount - w0, 1);
        chk("cafeAddr", {12'h0, lastWAddr}, 32'h00010);
        chk("cafeData", {16'h0, lastWData}, 32'hCAFE);
        chk("cafePostInc", {12'h0, ard_addr}, 32'h00011);

        // Wrap of the 12-bit address.
        doCmd(8'h3F, 0);
        doCmd(8'h7F, 0);
        chk("addrFFF", {12'h0, ard_addr}, 32'h00FFF);
        doCmd(8'h82, 0);
        chk("addrWrap", {12'h0, ard_addr}, 32'h00000);

        // Partial write discarded by an address command.
        w0 = wenCount;
        doCmd(8'hC1, 0);
        doCmd(8'hC2, 0);
        doCmd(8'h00, 0);
        doCmd(8'hC3, 0);
        doCmd(8'hC4, 0);
        doCmd(8'hC5, 0);
        doCmd(8'hC6, 0);
        chk("abortCount", wenCount - w0, 1);
        chk("abortData", {16'h0, lastWData}, 32'h3456);
        chk("abortAddr", {12'h0, lastWAddr}, 32'h00000);

        // Reset after nibble 3: the sequence is lost.
        doCmd(8'hC1, 0);
        doCmd(8'hC2, 0);
        doCmd(8'hC3, 0);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        #1 chkZeroOutputs("midResetOutputs");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        w0 = wenCount;
        doCmd(8'hD4, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("noWenAfterReset", wenCount - w0, 0);

        // req held high well past ack: one command only.
        doCmd(8'h2A, 0);
        doCmd(8'h82, 8);
        chk("heldReqSingleInc", {12'h0, ard_addr}, 32'h0002B);

        // req dropped right after latch.
        doEarlyDrop(8'h81);

        // Randomized command stream.
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            doCmd(8'($urandom), int'($urandom_range(0, 2)));
        end
        repeat (5) @(posedge clk);
        #1;
        chk("writeQueueDrained", wq.size(), 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/arduino_bridge.md
# arduino_bridge

Single-clock command bridge between the Arduino's 8-bit parallel bus and the Arduino-side port of the dual-port data RAM. The block synchronizes an asynchronous request strobe and decodes one command byte per four-phase req/ack handshake. It assembles a 12-bit word address, performs 16-bit reads and writes on the RAM's second port, and returns one byte per read. It replaces the direct nibble-address wiring into the RAM's Arduino port.

## Interface
Parameters:
- ADDR_W, 20, RAM Arduino-port address width; only bits [11:0] are programmable, bits [ADDR_W-1:12] are driven to 0.
- DATA_W, 16, RAM word width.

Ports:
- clk  in  1  system clock (clock domain of the RAM).
- rst  in  1  reset: asynchronous, active-low.
- req  in  1  Arduino request strobe; asynchronous to clk.
- data_in  in  8  Arduino command byte; stable from before req rises until ack rises.
- ack  out  1  handshake acknowledge.
- data_out  out  8  read-result byte; holds its value until the next READ.
- busy  out  1  high in every state except IDLE.
- ard_addr  out  ADDR_W  RAM port-B address.
- ard_wen  out  1  RAM port-B write enable, one-cycle pulse.
- ard_wdata  out  DATA_W  RAM port-B write data.
- ard_rdata  in  DATA_W  RAM port-B read data; registered, valid 1 cycle after the address is applied.

## Operation
- Command byte: [7:6] opcode, [5:0] payload.
- 00 ADDR_LO: addr[5:0] ← payload. Clears the nibble counter.
- 01 ADDR_HI: addr[11:6] ← payload. Clears the nibble counter.
- 10 READ:
  - payload[0] selects the byte: 0 gives rdata[7:0], 1 gives rdata[15:8].
  - payload[1] = post-increment addr.
- 11 WRITE:
  - wbuf ← {wbuf[11:0], payload[3:0]}, so nibbles are shifted in MSB-first; nib_cnt increments.
  - On the 4th nibble (nib_cnt==3 before the shift), ard_wdata ← the new wbuf and ard_wen pulses once. nib_cnt returns to 0.
  - payload[4] = post-increment after the write. payload[4] is ignored on nibbles 1–3.
- Post-increment operates on the 12-bit field. 0xFFF wraps to 0x000.
- ard_addr is the address register continuously. ard_wdata is registered.
- States:
  - IDLE: on a rising edge of the synchronized req, latch data_in into cmd and go to EXEC.
  - EXEC:
    - ADDR op goes to ACK.
    - READ goes to RD_WAIT.
    - WRITE with nibble 1–3 goes to ACK.
    - WRITE with the 4th nibble goes to WR.
  - RD_WAIT: one cycle while the RAM registers the address; go to RD_CAP.
  - RD_CAP: data_out ← the selected byte; apply post-increment; go to ACK.
  - WR: ard_wen=1 for this cycle only, with the pre-increment address; apply post-increment; go to ACK.
  - ACK: ack=1. Return to IDLE when the synchronized req is 0.

## Timing
- Reset (async assert, synchronous release) clears:
  - outputs: ack, data_out, busy, ard_addr, ard_wen, ard_wdata all 0.
  - internal: addr, wbuf, nib_cnt, sync flops all 0; state = IDLE.
- Reset mid-operation: ard_wen drops immediately, any partial nibble sequence is discarded, and the state is IDLE.
- Synchronizer: 2 flops plus an edge flop. req rising before clk edge k is seen as an edge in cycle k+2, and cmd is latched at edge k+2.
- Latency from latch to ack high:
  - ADDR and WRITE nibbles 1–3: 2 cycles.
  - WRITE nibble 4: 3 cycles.
  - READ: 4 cycles.
- ack falls 3 cycles after req falls (synchronizer delay plus the registered ack).
- New req edges are ignored in all states other than IDLE. A req that stays high does not retrigger.
- If req falls before ack rises, the operation still completes, and ack pulses for exactly 1 cycle.
- A read and a write are never issued in the same cycle.

## Structure
- Package arduino_bridge_pkg holds:
  - op_e enum: OP_ADDR_LO, OP_ADDR_HI, OP_READ, OP_WRITE.
  - state_e enum: IDLE, EXEC, RD_WAIT, RD_CAP, WR, ACK.
  - constants ADDR_W=20, DATA_W=16, PROG_ADDR_W=12, NIB_PER_WORD=4.
- Sub-module sync_2ff: a two-flop synchronizer with the same async active-low reset. It is instantiated for req and reused elsewhere.
- The FSM, address register, write shift buffer and read capture are in the top module.

## Test plan
- Reset then idle: rst low during random req/data activity → all outputs stay 0; after release, busy=0, ack=0.
- Address plus read: ADDR_LO 0x05, ADDR_HI 0x01 (addr=0x045); RAM model holds 0xBEEF at 0x045; READ payload 0b00 → data_out=0xEF, ack 4 cycles after latch; READ payload 0b01 → data_out=0xBE, addr unchanged.
- Four-nibble write: WRITE nibbles 0xC,0xA,0xF,0xE, with the 4th carrying increment, at addr 0x010 → exactly one ard_wen pulse with ard_wdata=0xCAFE, ard_addr=0x010; then ard_addr=0x011.
- Wrap: addr=0xFFF, READ with increment → ard_addr=0x000; ard_addr[19:12]=0 throughout.
- Partial write aborted: WRITE 0x1,0x2, then ADDR_LO 0x00, then 4 nibbles 0x3,0x4,0x5,0x6 → a single write of 0x3456 and no write of 0x12xx. Separately, rst asserted after nibble 3 → no ard_wen pulse.
- Handshake edges: req held high through ACK → exactly one command executed; req dropped 1 cycle after latch → op completes and ack pulses for exactly 1 cycle; ack falls 3 cycles after req falls.
